// File: rtl/execute_stage.sv
// RV64I execute stage with the EX/MEM pipeline register feeding memory_stage.
// MUL runs on an iterative shift-add unit that holds the front end via BusyE.
module execute_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteEnE,
  input  logic            MemtoRegE,
  input  logic            JALE,
  input  logic            JALRE,
  input  logic            MemReadEnE,
  input  logic            MemWriteEnE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      MemSizeE,
  input  logic [1:0]      LoadSizeE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      BranchTypeE,
  input  logic [4:0]      RdE,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmE,
  input  logic [XLEN-1:0] PcE,
  input  logic [XLEN-1:0] PcPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  input  logic            StallM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic            RegWriteEnM,
  output logic            MemtoRegM,
  output logic            JALM,
  output logic            MemReadEnM,
  output logic            MemWriteEnM,
  output logic [1:0]      MemSizeM,
  output logic [1:0]      LoadSizeM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PcPlus4M,
  output logic [XLEN-1:0] ReadData2M,
  output logic [XLEN-1:0] ALUResultM
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic            reg_write;
    logic            memto_reg;
    logic            jal;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic [1:0]      load_size;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] alu;
  } mreg_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  mreg_t           mreg_q, mreg_d;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, jalr_sum;
  logic [5:0]      shamt;
  logic            is_mul, busy, branch_cond;

  // Register indices are consumed by the hazard unit, not here.
  logic unused_idx;
  assign unused_idx = ^{Rs1E, Rs2E};

  assign is_mul = (ALUControlE == 4'b1010);
  assign shamt  = src_b[5:0];

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = mreg_q.alu;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = mreg_q.alu;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmE : fwd_b;
  end

  always_comb begin
    case (ALUControlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = src_a << shamt;
      4'b0110: alu_result = src_a >> shamt;
      4'b0111: alu_result = $signed(src_a) >>> shamt;
      4'b1000: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b1001: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b1010: alu_result = acc_q;
      4'b1011: alu_result = src_b;
      default: alu_result = src_a + src_b;
    endcase
  end

  always_comb begin
    case (BranchTypeE)
      3'b000:  branch_cond = (src_a == fwd_b);
      3'b001:  branch_cond = (src_a != fwd_b);
      3'b100:  branch_cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  branch_cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  branch_cond = (src_a < fwd_b);
      3'b111:  branch_cond = (src_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + ImmE;
  assign PCSrcE    = !rst && !FlushE && ((BranchE && branch_cond) || JALE || JALRE);
  assign PCTargetE = JALRE ? {jalr_sum[XLEN-1:1], 1'b0} : (PcE + ImmE);

  // StallM freezes the multiplier in every state, including the launch from IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mul && !FlushE) begin
          busy = 1'b1;
          if (!StallM) begin
            state_d  = RUN;
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!StallM) begin
          if (FlushE) begin
            state_d = IDLE;
          end else begin
            if (mcand_q[cnt_q]) acc_d = acc_q + (mplier_q << cnt_q);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!StallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BusyE = busy && !rst;

  always_comb begin
    mreg_d = mreg_q;
    if (!StallM) begin
      if (FlushE || BusyE) begin
        mreg_d = '0;
      end else begin
        mreg_d.reg_write = RegWriteEnE;
        mreg_d.memto_reg = MemtoRegE;
        mreg_d.jal       = JALE;
        mreg_d.mem_read  = MemReadEnE;
        mreg_d.mem_write = MemWriteEnE;
        mreg_d.mem_size  = MemSizeE;
        mreg_d.load_size = LoadSizeE;
        mreg_d.rd        = RdE;
        mreg_d.pc_plus4  = PcPlus4E;
        mreg_d.rd2       = fwd_b;
        mreg_d.alu       = alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mreg_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mreg_q   <= mreg_d;
    end
  end

  assign RegWriteEnM = mreg_q.reg_write;
  assign MemtoRegM   = mreg_q.memto_reg;
  assign JALM        = mreg_q.jal;
  assign MemReadEnM  = mreg_q.mem_read;
  assign MemWriteEnM = mreg_q.mem_write;
  assign MemSizeM    = mreg_q.mem_size;
  assign LoadSizeM   = mreg_q.load_size;
  assign RdM         = mreg_q.rd;
  assign PcPlus4M    = mreg_q.pc_plus4;
  assign ReadData2M  = mreg_q.rd2;
  assign ALUResultM  = mreg_q.alu;

endmodule
